// File: rtl/fifo_rd_fwft.sv
// Read-side adapter behind an async FIFO: turns the rd_en/empty interface (data one cycle
// after rd_en) into a first-word-fall-through valid/ready stream with a 2-entry prefetch buffer.
module fifo_rd_fwft #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    input  logic                  i_fifo_rd_empty,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic [1:0]            o_level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic                  pend_reg;
    logic [DATA_WIDTH-1:0] slot0_reg, slot0_next;
    logic [DATA_WIDTH-1:0] slot1_reg, slot1_next;
    logic                  pop;
    logic [2:0]            occupancy;

    assign o_m_valid = (state_reg != EMPTY);
    assign o_m_data  = slot0_reg;
    assign o_level   = state_reg;
    assign pop       = o_m_valid & i_m_ready;

    // Words that will be held after this edge, counting the read already in flight.
    assign occupancy = {1'b0, state_reg} + {2'b00, pend_reg} - {2'b00, pop};

    // Gated by reset so no read is issued while the FIFO read side is also in reset.
    assign o_fifo_rd_en = i_rst_n & ~i_fifo_rd_empty & (occupancy < 3'd2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= EMPTY;
            pend_reg  <= 1'b0;
            slot0_reg <= '0;
            slot1_reg <= '0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= o_fifo_rd_en;
            slot0_reg <= slot0_next;
            slot1_reg <= slot1_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        slot0_next = slot0_reg;
        slot1_next = slot1_reg;
        case (state_reg)
            EMPTY: begin
                if (pend_reg) begin
                    slot0_next = i_fifo_rd_data;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (pend_reg && pop) begin
                    slot0_next = i_fifo_rd_data;
                end else if (pend_reg) begin
                    slot1_next = i_fifo_rd_data;
                    state_next = TWO;
                end else if (pop) begin
                    // Head keeps stale data; o_m_valid masks it.
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    slot0_next = slot1_reg;
                    if (pend_reg) begin
                        slot1_next = i_fifo_rd_data;
                    end else begin
                        state_next = ONE;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (occupancy <= 3'd2);
            assert (!(state_reg == TWO && pop && pend_reg));
        end
    end
`endif

endmodule
